sgdmac_wr_cmd_arb: RTL and testbench
====================================

// Module: sgdmac_wr_cmd_arb
// PURPOSE
//  Shares one SG-DMA write engine among N_CH descriptor channels. Each channel offers a
//  48-bit write command {dst_addr[31:0], byte_count[15:0]}. The block grants round-robin,
//  launches the engine with a one-cycle start pulse, waits for the engine to return to idle,
//  then reports per-command completion. It sits between the descriptor units and the engine.
// PARAMETERS
//  N_CH        4      number of requesting channels (2..8)
//  CH_W        $clog2(N_CH)  channel-index width (derived, not overridden)
//  WDT_CYCLES  65535  busy-cycle limit before watchdog fires (only with SGDMAC_WR_ARB_WDT_EN)
// PORTS
//  clk            in   1         clock; all logic on rising edge
//  rst            in   1         synchronous reset, active-high
//  req_valid_i    in   N_CH      per-channel command valid
//  req_cmd_i      in   48*N_CH   per-channel command; channel k at [48*k+47:48*k]
//  req_ready_o    out  N_CH      one-hot accept strobe; command taken when valid&ready
//  eng_start_o    out  1         start pulse to write engine
//  eng_cmd_o      out  48        command to write engine, held stable while busy_o=1
//  eng_done_i     in   1         engine idle indication (high when engine is idle)
//  cpl_valid_o    out  1         one-cycle completion pulse, no backpressure
//  cpl_ch_o       out  CH_W      channel of the completing command
//  cpl_err_o      out  1         1 = command rejected as malformed, never issued
//  busy_o         out  1         high from accept through completion
//  wdt_timeout_o  out  1         sticky watchdog flag (0 when macro is undefined)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=ARB, rr_ptr=0, eng_cmd_o=0, wdt counter=0. A reset during any state
//    aborts the command without a completion. The same reset also drives the engine (inverted).
//  - FSM ARB -> ISSUE -> BUSY -> CPL -> ARB. The reject path is ARB -> CPL.
//  - ARB: grant only when eng_done_i=1 and any req_valid_i is set. The winner is the first valid
//    channel scanning rr_ptr, rr_ptr+1, ... (mod N_CH). req_ready_o[winner]=1 for that cycle only
//    (combinational from valid and state). Latch the cmd and channel. Set rr_ptr <= winner+1 (mod N_CH).
//  - Malformed: byte_count==0, byte_count[1:0]!=0, or dst_addr[1:0]!=0. The command is still
//    accepted and goes to CPL with cpl_err_o=1. eng_start_o is never asserted for it.
//  - ISSUE: eng_start_o=1 for exactly one cycle, with eng_cmd_o valid in the same cycle.
//    The engine drops eng_done_i on the next cycle.
//  - BUSY: ignore eng_done_i on the first BUSY cycle (blanking, 1 cycle). After that, eng_done_i=1
//    moves to CPL.
//  - CPL: cpl_valid_o=1, cpl_ch_o=latched channel, cpl_err_o per the reject flag. Next state is ARB.
//  - Latency: accept at T, start at T+1, earliest completion pulse one cycle after the engine
//    reasserts done. After CPL, at least one ARB cycle occurs before the next accept.
//  - busy_o = (state != ARB). eng_cmd_o holds its value after completion until the next accept.
//  - Requests dropped or changed while not granted are legal. Inputs are sampled only at accept.
// CONFIGURATION
//  SGDMAC_WR_ARB_WDT_EN defined:
//  - A 32-bit counter clears on entry to ISSUE and increments each BUSY cycle.
//  - When the count reaches WDT_CYCLES, wdt_timeout_o <= 1 and stays set until rst.
//  - The FSM stays in BUSY and never fakes a completion.
//  Undefined: no counter is built and wdt_timeout_o is tied 0.
// TESTING
//  1. Reset, ch1 cmd {0x1000_0000, 0x0040}, done=1 -> req_ready_o=0010 at T,
//     eng_start_o at T+1 with eng_cmd_o=0x1000_0000_0040. Done back 10 cycles later
//     -> cpl_valid_o, cpl_ch_o=1, cpl_err_o=0.
//  2. All 4 channels valid continuously, engine completing each in 5 cycles
//     -> grant order 0,1,2,3,0,1. No start while eng_done_i=0.
//  3. ch2 cmd byte_count=0x0006 -> accepted, no eng_start_o, cpl_valid_o with cpl_ch_o=2
//     and cpl_err_o=1 on the next cycle.
//  4. Assert rst in BUSY with done=0 -> next cycle all outputs 0. No cpl_valid_o.
//     The next grant goes to ch0.
//  5. Change req_cmd_i of the granted channel during BUSY -> eng_cmd_o unchanged until completion.
//  6. (WDT_EN, WDT_CYCLES=100) hold done=0 after start -> wdt_timeout_o rises after the
//     100th BUSY cycle and stays 1. busy_o stays 1.

Source files
------------

// File: rtl/sgdmac_wr_cmd_arb.sv
// Round-robin arbiter sharing one SG-DMA write engine among N_CH channels.
// Optional busy watchdog: define SGDMAC_WR_ARB_WDT_EN.
module sgdmac_wr_cmd_arb #(
    parameter int N_CH       = 4,
    parameter int CH_W       = $clog2(N_CH),
    parameter int WDT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req_valid_i,
    input  logic [48*N_CH-1:0]   req_cmd_i,
    output logic [N_CH-1:0]      req_ready_o,
    output logic                 eng_start_o,
    output logic [47:0]          eng_cmd_o,
    input  logic                 eng_done_i,
    output logic                 cpl_valid_o,
    output logic [CH_W-1:0]      cpl_ch_o,
    output logic                 cpl_err_o,
    output logic                 busy_o,
    output logic                 wdt_timeout_o
);

    if (N_CH < 2 || N_CH > 8 || WDT_CYCLES < 1) begin : g_bad_param
        $error("sgdmac_wr_cmd_arb: N_CH must be 2..8, WDT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        CPL   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_nxt;
    logic [CH_W-1:0] win;
    logic [CH_W:0]   scan;
    logic [CH_W:0]   win_inc;
    logic            found;
    logic            grant;
    logic [47:0]     win_cmd;
    logic            bad;

    logic [47:0]     cmd_q;
    logic [CH_W-1:0] ch_q;
    logic            err_q;
    logic            first_busy;

    // First valid channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (scan >= (CH_W+1)'(N_CH))
                scan = scan - (CH_W+1)'(N_CH);
            if (!found && req_valid_i[scan[CH_W-1:0]]) begin
                found = 1'b1;
                win   = scan[CH_W-1:0];
            end
        end
    end

    assign grant   = (state == ARB) && eng_done_i && found;
    assign win_cmd = req_cmd_i[48*int'(win) +: 48];
    assign bad     = (win_cmd[15:0] == 16'h0000)
                  || (win_cmd[1:0] != 2'b00)
                  || (win_cmd[17:16] != 2'b00);

    assign win_inc = {1'b0, win} + 1'b1;
    assign rr_nxt  = (win_inc == (CH_W+1)'(N_CH)) ? '0
                                                  : win_inc[CH_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            state <= ARB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB: begin
                if (grant)
                    state_nxt = bad ? CPL : ISSUE;
            end
            ISSUE: state_nxt = BUSY;
            // done may still read high on the first BUSY cycle
            BUSY: begin
                if (!first_busy && eng_done_i)
                    state_nxt = CPL;
            end
            CPL: state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (grant)
            req_ready_o = N_CH'(1) << win;
        eng_start_o = (state == ISSUE);
        busy_o      = (state != ARB);
        cpl_valid_o = (state == CPL);
        cpl_ch_o    = (state == CPL) ? ch_q : '0;
        cpl_err_o   = (state == CPL) && err_q;
        eng_cmd_o   = cmd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            cmd_q      <= '0;
            ch_q       <= '0;
            err_q      <= 1'b0;
            first_busy <= 1'b0;
        end else begin
            first_busy <= (state == ISSUE);
            if (grant) begin
                cmd_q  <= win_cmd;
                ch_q   <= win;
                err_q  <= bad;
                rr_ptr <= rr_nxt;
            end
        end
    end

`ifdef SGDMAC_WR_ARB_WDT_EN
    logic [31:0] wdt_cnt;
    logic        wdt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else begin
            if (state == ISSUE)
                wdt_cnt <= '0;
            else if (state == BUSY && wdt_cnt != '1)
                wdt_cnt <= wdt_cnt + 32'd1;
            if (state == BUSY && (wdt_cnt + 32'd1) >= 32'(WDT_CYCLES))
                wdt_q <= 1'b1;
        end
    end

    assign wdt_timeout_o = wdt_q;
`else
    assign wdt_timeout_o = 1'b0;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready_o));

    a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
        (state == BUSY) |-> $stable(eng_cmd_o));

    a_no_start_rejected: assert property (@(posedge clk) disable iff (rst)
        (state == ISSUE) |-> !err_q);

endmodule

// File: tb/tb_sgdmac_wr_cmd_arb.sv
// Scoreboard bench for sgdmac_wr_cmd_arb: grants, starts and completions
// are queued by the stimulus and checked by an independent monitor.
module tb_sgdmac_wr_cmd_arb;

    localparam int N = 4;
`ifdef SGDMAC_WR_ARB_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [48*N-1:0] req_cmd = '0;
    logic [N-1:0]   req_ready;
    logic           eng_start;
    logic [47:0]    eng_cmd;
    logic           eng_done = 1'b1;
    logic           cpl_valid;
    logic [1:0]     cpl_ch;
    logic           cpl_err;
    logic           busy;
    logic           wdt;

    sgdmac_wr_cmd_arb #(.N_CH(N), .WDT_CYCLES(100)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_cmd_i     (req_cmd),
        .req_ready_o   (req_ready),
        .eng_start_o   (eng_start),
        .eng_cmd_o     (eng_cmd),
        .eng_done_i    (eng_done),
        .cpl_valid_o   (cpl_valid),
        .cpl_ch_o      (cpl_ch),
        .cpl_err_o     (cpl_err),
        .busy_o        (busy),
        .wdt_timeout_o (wdt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h required nothing", name, act);
    endtask

    // Engine model: done falls after start (optionally one cycle late),
    // rises again after eng_lat low cycles; reset forces it idle.
    int eng_lat = 10;
    bit eng_slow = 1'b0;
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            eng_done <= 1'b1;
            eng_cnt  <= 0;
        end else if (eng_start) begin
            eng_cnt  <= eng_lat + int'(eng_slow);
            eng_done <= eng_slow;
        end else if (eng_cnt != 0) begin
            eng_cnt  <= eng_cnt - 1;
            eng_done <= (eng_cnt == 1);
        end
    end

    logic [N-1:0] q_grant[$];
    logic [47:0]  q_start[$];
    logic [2:0]   q_cpl[$];

    int   cyc = 0;
    int   g_cyc = 0;
    int   rise_cyc = 0;
    int   n_grant = 0;
    bit   pend = 1'b0;
    logic prev_done = 1'b1;

    always @(negedge clk) begin
        logic [2:0] e;
        cyc++;
        if (rst) begin
            pend = 1'b0;
            prev_done = eng_done;
        end else begin
            if (eng_done && !prev_done) begin
                rise_cyc = cyc;
                pend = 1'b1;
            end
            prev_done = eng_done;
            if (req_ready != '0) begin
                n_grant++;
                g_cyc = cyc;
                if (q_grant.size() == 0)
                    fail_now("unexpected_grant", 64'(req_ready));
                else
                    chk("grant", 64'(req_ready), 64'(q_grant.pop_front()));
            end
            if (eng_start) begin
                pend = 1'b0;
                chk("start_latency", 64'(cyc), 64'(g_cyc + 1));
                chk("start_while_idle", 64'(eng_done), 64'd1);
                if (q_start.size() == 0)
                    fail_now("unexpected_start", 64'(eng_cmd));
                else
                    chk("start_cmd", 64'(eng_cmd), 64'(q_start.pop_front()));
            end
            if (cpl_valid) begin
                if (q_cpl.size() == 0) begin
                    fail_now("unexpected_cpl", 64'({cpl_err, cpl_ch}));
                end else begin
                    e = q_cpl.pop_front();
                    chk("cpl_ch", 64'(cpl_ch), 64'(e[1:0]));
                    chk("cpl_err", 64'(cpl_err), 64'(e[2]));
                    if (e[2]) begin
                        chk("reject_latency", 64'(cyc), 64'(g_cyc + 1));
                    end else begin
                        chk("cpl_after_done", 64'(pend), 64'd1);
                        chk("cpl_latency", 64'(cyc), 64'(rise_cyc + 1));
                    end
                end
                pend = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_cmd(input int ch, input logic [31:0] a,
                           input logic [15:0] b);
        req_cmd[48*ch +: 48] = {a, b};
    endtask

    task automatic wait_grants(input int n);
        int tgt;
        int t;
        tgt = n_grant + n;
        t = 0;
        while (n_grant < tgt && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (n_grant < tgt)
            fail_now("grant_timeout", 64'(n_grant));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy)
            fail_now("idle_timeout", 64'(busy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: got %0d required finish", cyc);
        $fatal(1, "timeout");
    end

    int          order[6] = '{0, 1, 2, 3, 0, 1};
    logic [47:0] cmds[4] = '{48'h2000_0000_0010, 48'h2000_0100_0020,
                             48'h2000_0200_0030, 48'h2000_0300_0040};

    initial begin
        do_reset();
        chk("reset_outs", 64'({busy, eng_start, cpl_valid, cpl_err,
                               cpl_ch, wdt, req_ready}), 64'd0);
        chk("reset_cmd", 64'(eng_cmd), 64'd0);

        // single good command on ch1
        eng_lat = 10;
        set_cmd(1, 32'h1000_0000, 16'h0040);
        q_grant.push_back(4'b0010);
        q_start.push_back(48'h1000_0000_0040);
        q_cpl.push_back({1'b0, 2'd1});
        req_valid = 4'b0010;
        wait_grants(1);
        req_valid = '0;
        wait_idle();
        chk("cmd_hold_after_cpl", 64'(eng_cmd), 64'h1000_0000_0040);

        // all channels requesting, done held high one extra cycle
        do_reset();
        eng_lat = 5;
        eng_slow = 1'b1;
        for (int k = 0; k < 4; k++)
            req_cmd[48*k +: 48] = cmds[k];
        for (int k = 0; k < 6; k++) begin
            q_grant.push_back(4'b0001 << order[k]);
            q_start.push_back(cmds[order[k]]);
            q_cpl.push_back({1'b0, 2'(order[k])});
        end
        req_valid = 4'b1111;
        wait_grants(6);
        req_valid = '0;
        wait_idle();
        eng_slow = 1'b0;

        // malformed: bad count, bad address, zero count
        set_cmd(2, 32'h3000_0000, 16'h0006);
        set_cmd(3, 32'h3000_0002, 16'h0040);
        set_cmd(0, 32'h3000_0000, 16'h0000);
        q_grant.push_back(4'b0100);
        q_cpl.push_back({1'b1, 2'd2});
        q_grant.push_back(4'b1000);
        q_cpl.push_back({1'b1, 2'd3});
        q_grant.push_back(4'b0001);
        q_cpl.push_back({1'b1, 2'd0});
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = 4'b0001;
        wait_grants(1);
        req_valid = '0;
        wait_idle();

        // reset while busy aborts without completion
        eng_lat = 60;
        set_cmd(0, 32'h4000_0000, 16'h0100);
        q_grant.push_back(4'b0001);
        q_start.push_back(48'h4000_0000_0100);
        req_valid = 4'b0001;
        wait_grants(1);
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_rst", 64'({busy, eng_done}), 64'b10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_outs", 64'({busy, eng_start, cpl_valid, cpl_err,
                               cpl_ch, wdt, req_ready}), 64'd0);
        chk("abort_cmd", 64'(eng_cmd), 64'd0);
        eng_lat = 4;
        set_cmd(0, 32'h4100_0000, 16'h0008);
        set_cmd(3, 32'h4300_0000, 16'h000c);
        q_grant.push_back(4'b0001);
        q_start.push_back(48'h4100_0000_0008);
        q_cpl.push_back({1'b0, 2'd0});
        q_grant.push_back(4'b1000);
        q_start.push_back(48'h4300_0000_000c);
        q_cpl.push_back({1'b0, 2'd3});
        req_valid = 4'b1001;
        wait_grants(1);
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = '0;
        wait_idle();

        // granted channel changes its command while busy
        eng_lat = 10;
        set_cmd(1, 32'h5000_0000, 16'h0080);
        q_grant.push_back(4'b0010);
        q_start.push_back(48'h5000_0000_0080);
        q_cpl.push_back({1'b0, 2'd1});
        req_valid = 4'b0010;
        wait_grants(1);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        set_cmd(1, 32'hdead_bee0, 16'h0004);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cmd_stable_busy", 64'(eng_cmd), 64'h5000_0000_0080);
        end
        wait_idle();
        chk("cmd_hold_after_change", 64'(eng_cmd), 64'h5000_0000_0080);

        // engine never returns: watchdog (if built) and busy stay up
        eng_lat = 400;
        set_cmd(2, 32'h6000_0000, 16'h0010);
        q_grant.push_back(4'b0100);
        q_start.push_back(48'h6000_0000_0010);
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = '0;
        @(negedge clk);
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            chk("wdt_flag", 64'(wdt), 64'(WDT_ON && (k > 100)));
        end
        chk("busy_hang", 64'({busy, cpl_valid}), 64'b10);
        do_reset();
        chk("wdt_after_rst", 64'(wdt), 64'd0);

        chk("q_grant_empty", 64'(q_grant.size()), 64'd0);
        chk("q_start_empty", 64'(q_start.size()), 64'd0);
        chk("q_cpl_empty", 64'(q_cpl.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
